// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared UART constants and types
//
// Purpose: constants shared by the UART RX controller and the RX-side FIFO
//          so both agree on byte width and default buffer depth.
// Ports:   none (package).

package uart_rx_fifo_pkg;

  // Width of one UART character as produced by the RX controller.
  localparam int UART_DATA_W = 8;

  // Default number of buffered RX bytes; must be a power of two, >= 2.
  localparam int UART_RXFIFO_DEPTH = 16;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - RX byte capture and FWFT consumer interface
//
// Purpose: bundles the RX-controller strobe side, the first-word-fall-through
//          consumer side and the status flags of the RX FIFO.
// Signals:
//   rx_done, rx_data       byte strobe and byte from the RX controller
//   m_valid, m_data        head entry towards the consumer
//   m_ready                consumer accepts head when m_valid & m_ready
//   count, full, empty     occupancy status
//   overflow, clr_overflow sticky overrun flag and its single-cycle clear
// Modports:
//   master  environment side (RX controller + consumer)
//   slave   FIFO side

interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = UART_RXFIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic              rx_done;
  logic [DATA_W-1:0] rx_data;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              clr_overflow;

  modport master (
    output rx_done, rx_data, m_ready, clr_overflow,
    input  m_valid, m_data, count, full, empty, overflow
  );

  modport slave (
    input  rx_done, rx_data, m_ready, clr_overflow,
    output m_valid, m_data, count, full, empty, overflow
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x DATA_W register array for UART FIFOs
//
// Purpose: dual-port storage, synchronous write and asynchronous read.
//          Contents are deliberately not reset; the owning FIFO tracks
//          validity through its pointers.
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  combinational read data at raddr

module uart_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte FIFO with FWFT output
//
// Purpose: captures each byte strobed by the RX controller into a circular
//          buffer, presents the oldest byte first-word-fall-through, reports
//          occupancy and flags overrun when a byte arrives while full.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset; discards all contents
//   bus    uart_rx_fifo_if.slave: rx_done/rx_data in, m_valid/m_data/m_ready
//          consumer handshake, count/full/empty/overflow status,
//          clr_overflow clear input
//
// DEPTH must be a power of two and at least 2.

module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = UART_RXFIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   wr_nxt;
  logic [ADDR_W:0]   rd_nxt;

  logic [ADDR_W:0]   count_q;
  logic              full_q;
  logic              empty_q;
  logic              m_valid_q;
  logic [DATA_W-1:0] m_data_q;
  logic              overflow_q;

  logic              push;
  logic              pop;
  logic              ovf_set;
  logic [DATA_W-1:0] head_rd;
  logic [DATA_W-1:0] head_nxt;

  assign pop     = m_valid_q & bus.m_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push    = bus.rx_done & (~full_q | pop);
  assign ovf_set = bus.rx_done & full_q & ~pop;

  assign wr_nxt  = wr_ptr + {{ADDR_W{1'b0}}, push};
  assign rd_nxt  = rd_ptr + {{ADDR_W{1'b0}}, pop};

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.rx_data),
    .raddr (rd_nxt[ADDR_W-1:0]),
    .rdata (head_rd)
  );

  // The output register is loaded with the entry that will be at the head
  // after this edge. If that entry is the byte being written right now it is
  // not in the array yet, so it is forwarded straight from rx_data.
  assign head_nxt = (push && (rd_nxt == wr_ptr)) ? bus.rx_data : head_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      count_q   <= wr_nxt - rd_nxt;
      empty_q   <= (wr_nxt == rd_nxt);
      m_valid_q <= (wr_nxt != rd_nxt);
      full_q    <= (wr_nxt[ADDR_W-1:0] == rd_nxt[ADDR_W-1:0]) &&
                   (wr_nxt[ADDR_W] != rd_nxt[ADDR_W]);
      // When the FIFO drains to empty the last value is simply held.
      if (wr_nxt != rd_nxt) begin
        m_data_q <= head_nxt;
      end
      // A new overrun in the clearing cycle wins over the clear.
      overflow_q <= ovf_set | (overflow_q & ~bus.clr_overflow);
    end
  end

  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.count    = count_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo

module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(8)) bus ();

  uart_rx_fifo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue-level reference: the FIFO is just an ordered list of bytes plus
  // a sticky overrun bit.
  logic [7:0] mq[$];
  logic       ovf_m;

  initial ovf_m = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      ovf_m = 1'b0;
    end else begin
      automatic bit do_pop  = (mq.size() > 0) && bus.m_ready;
      automatic bit room    = (mq.size() < DEPTH) || do_pop;
      automatic bit do_push = bus.rx_done && room;
      automatic bit drop    = bus.rx_done && !room;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(bus.rx_data);
      ovf_m = drop || (ovf_m && !bus.clr_overflow);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the reference.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        chk("cmp_m_valid", 32'(bus.m_valid), 32'(mq.size() != 0));
        chk("cmp_count", 32'(bus.count), 32'(mq.size()));
        chk("cmp_full", 32'(bus.full), 32'(mq.size() == DEPTH));
        chk("cmp_empty", 32'(bus.empty), 32'(mq.size() == 0));
        chk("cmp_overflow", 32'(bus.overflow), 32'(ovf_m));
        if (mq.size() != 0) chk("cmp_m_data", 32'(bus.m_data), 32'(mq[0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Apply one set of inputs for exactly one rising edge; returns at the next
  // falling edge with inputs back to idle.
  task automatic drive(input logic rd, input logic [7:0] d, input logic rdy, input logic clr);
    bus.rx_done      = rd;
    bus.rx_data      = rd ? d : 8'h00;
    bus.m_ready      = rdy;
    bus.clr_overflow = clr;
    @(negedge clk);
    bus.rx_done      = 1'b0;
    bus.rx_data      = 8'h00;
    bus.m_ready      = 1'b0;
    bus.clr_overflow = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, base + 8'(i), 1'b0, 1'b0);
  endtask

  task automatic drain_seq(input string name, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      chk({name, "_valid"}, 32'(bus.m_valid), 32'd1);
      chk({name, "_data"}, 32'(bus.m_data), 32'(base + 8'(i)));
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    bus.m_ready = 1'b0;
    bus.clr_overflow = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte, 1-cycle latency, then pop
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("single_valid", 32'(bus.m_valid), 32'd1);
    chk("single_data", 32'(bus.m_data), 32'hA5);
    chk("single_count", 32'(bus.count), 32'd1);
    chk("single_empty", 32'(bus.empty), 32'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("single_pop_valid", 32'(bus.m_valid), 32'd0);
    chk("single_pop_count", 32'(bus.count), 32'd0);
    chk("single_pop_empty", 32'(bus.empty), 32'd1);

    // Fill to full, then overrun
    fill(8'h00);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd16);
    chk("fill_head", 32'(bus.m_data), 32'h00);
    chk("model_size_full", 32'(mq.size()), 32'd16);
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovr_flag", 32'(bus.overflow), 32'd1);
    chk("ovr_count", 32'(bus.count), 32'd16);
    chk("ovr_head", 32'(bus.m_data), 32'h00);
    chk("model_ovf", 32'(ovf_m), 32'd1);
    drain_seq("drain1", 8'h00, 16);
    chk("drain1_empty", 32'(bus.empty), 32'd1);
    chk("drain1_ovf_sticky", 32'(bus.overflow), 32'd1);

    // Clear alone
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_alone", 32'(bus.overflow), 32'd0);

    // Simultaneous push/pop while full
    fill(8'h40);
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    chk("pp_full_ovf", 32'(bus.overflow), 32'd0);
    chk("pp_full_count", 32'(bus.count), 32'd16);
    chk("pp_full_flag", 32'(bus.full), 32'd1);
    drain_seq("drain2", 8'h41, 15);
    chk("drain2_last_valid", 32'(bus.m_valid), 32'd1);
    chk("drain2_last_data", 32'(bus.m_data), 32'h77);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain2_empty", 32'(bus.empty), 32'd1);

    // Overrun in the same cycle as clear: set wins
    fill(8'h50);
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("clr_vs_set", 32'(bus.overflow), 32'd1);
    chk("clr_vs_set_count", 32'(bus.count), 32'd16);
    drain_seq("drain3", 8'h50, 16);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_again", 32'(bus.overflow), 32'd0);

    // m_ready while empty has no effect
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ready_empty_count", 32'(bus.count), 32'd0);
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("push_empty_rdy_count", 32'(bus.count), 32'd1);
    chk("push_empty_rdy_data", 32'(bus.m_data), 32'h5A);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap-around streaming, one push per two cycles with m_ready high
    for (int i = 0; i < 40; i++) begin
      automatic logic [7:0] b = 8'h10 + 8'(i);
      drive(1'b1, b, 1'b1, 1'b0);
      chk("wrap_valid", 32'(bus.m_valid), 32'd1);
      chk("wrap_data", 32'(bus.m_data), 32'(b));
      chk("wrap_count", 32'(bus.count), 32'd1);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap_count_pop", 32'(bus.count), 32'd0);
    end

    // Reset mid-stream with 5 bytes stored and overflow set
    fill(8'h60);
    drive(1'b1, 8'hDD, 1'b0, 1'b0);
    drain_seq("drain4", 8'h60, 11);
    chk("pre_rst_count", 32'(bus.count), 32'd5);
    chk("pre_rst_ovf", 32'(bus.overflow), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_empty", 32'(bus.empty), 32'd1);
    chk("arst_overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("post_rst_valid", 32'(bus.m_valid), 32'd1);
    chk("post_rst_data", 32'(bus.m_data), 32'h3C);
    chk("post_rst_count", 32'(bus.count), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_empty", 32'(bus.empty), 32'd1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
